// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder sequencer: drives an external combinational 4-bit
// full adder one nibble per clock, LSB nibble first, rippling carry through c_reg.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset_p,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   overflow,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_carry
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_reg, b_reg;
  logic           c_reg;
  logic [IW-1:0]  idx;
  logic           accept;
  logic           last;
  logic [IW+1:0]  bitpos;
  logic [W-1:0]   a_sh, b_sh;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    bitpos    = {idx, 2'b00};
    a_sh      = a_reg >> bitpos;
    b_sh      = b_reg >> bitpos;
    last      = (idx == IW'(NIBBLES - 1));
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = a_sh[3:0];
        add_b   = b_sh[3:0];
        add_cin = c_reg;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        accept    = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      c_reg    <= 1'b0;
      idx      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg    <= a;
        b_reg    <= b;
        c_reg    <= cin;
        idx      <= '0;
        result   <= '0;
        cout     <= 1'b0;
        overflow <= 1'b0;
      end else if (state == RUN) begin
        result[bitpos +: 4] <= add_sum;
        c_reg               <= add_carry;
        idx                 <= idx + IW'(1);
        // Signed overflow: operands agree in sign but the final sum MSB differs.
        if (last) begin
          cout     <= add_carry;
          overflow <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[3] != a_reg[W-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: transaction-level arithmetic model
// checked every cycle, plus directed cases with literal expectations.
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic          clk = 1'b0;
  logic          reset_p, start, cin;
  logic [W-1:0]  a, b;
  logic          busy, done, cout, overflow;
  logic [W-1:0]  result;
  logic [3:0]    add_a, add_b, add_sum;
  logic          add_cin, add_carry;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk(clk), .reset_p(reset_p), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_carry(add_carry)
  );

  // Behavioural stand-in for the external 4-bit full adder.
  assign {add_carry, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: phase = cycles since the op was accepted (0 = none).
  int      phase = 0;
  bit      model_ready = 0;
  longint  op_a, op_b, op_cin, exp_res;
  logic    exp_cout, exp_ovf;
  longint  mask = (longint'(1) << W) - 1;
  longint  smax = (longint'(1) << (W - 1)) - 1;
  longint  smin = -(longint'(1) << (W - 1));

  function automatic longint sext(input longint v);
    return v[W-1] ? v - (longint'(1) << W) : v;
  endfunction

  always @(posedge clk) begin
    longint s, ss;
    model_ready = 1;
    if (reset_p) begin
      phase = 0; exp_res = 0; exp_cout = 0; exp_ovf = 0;
    end else if (phase >= 1 && phase <= N) begin
      phase++;
      if (phase == N + 1) begin
        s        = op_a + op_b + op_cin;
        exp_res  = s & mask;
        exp_cout = ((s >> W) & 1) != 0;
        ss       = sext(op_a) + sext(op_b) + op_cin;
        exp_ovf  = (ss > smax) || (ss < smin);
      end
    end else if (start) begin
      phase = 1;
      op_a = longint'(a); op_b = longint'(b); op_cin = longint'(cin);
      exp_res = 0; exp_cout = 0; exp_ovf = 0;
    end else begin
      phase = 0;
    end
  end

  always @(negedge clk) begin
    int     j;
    longint m;
    logic   run;
    if (model_ready) begin
      run = (phase >= 1 && phase <= N);
      chk("busy", busy, run);
      chk("done", done, phase == N + 1);
      if (run) begin
        j = phase - 1;
        m = (longint'(1) << (4 * j)) - 1;
        chk("add_a", add_a, (op_a >> (4 * j)) & 15);
        chk("add_b", add_b, (op_b >> (4 * j)) & 15);
        chk("add_cin", add_cin, ((op_a & m) + (op_b & m) + op_cin) >> (4 * j));
        chk("partial_result", result, (op_a + op_b + op_cin) & m);
        chk("cout_run", cout, 0);
        chk("ovf_run", overflow, 0);
      end else begin
        chk("add_a_idle", add_a, 0);
        chk("add_b_idle", add_b, 0);
        chk("add_cin_idle", add_cin, 0);
        chk("result", result, exp_res);
        chk("cout", cout, exp_cout);
        chk("overflow", overflow, exp_ovf);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done; cyc counts negedges from the first RUN cycle.
  task automatic wait_done(output int cyc, output logic [3:0] cins);
    cyc  = -1;
    cins = '0;
    for (int i = 0; i < 4 * N + 10; i++) begin
      @(negedge clk);
      if (busy && i < N) cins[i] = add_cin;
      if (done) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic do_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input logic [W-1:0] er, input logic ec, input logic eo,
                       output logic [3:0] cins);
    int cyc;
    a = av; b = bv; cin = cv; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(cyc, cins);
    chk({name, "_latency"}, cyc, N);
    chk({name, "_result"}, result, er);
    chk({name, "_cout"}, cout, ec);
    chk({name, "_ovf"}, overflow, eo);
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] cins;
    int         cnt, t1, t2, cyc;
    logic [W-1:0] r_seen;

    reset_p = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {cout, overflow}, 0);
    chk("rst_adder_if", {add_a, add_b, add_cin}, 0);
    step();
    reset_p = 1'b0;
    step();

    do_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, cins);
    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, cins);
    chk("ripple_cin_seq", cins, 4'b1110);
    do_op("sovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, cins);
    do_op("cin_flags", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1, cins);

    // Start during RUN must be ignored.
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1; a = 16'hAAAA;
    step();
    start = 1'b0;
    cnt = 0; r_seen = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        r_seen = result;
      end
    end
    chk("ignore_done_count", cnt, 1);
    chk("ignore_result", r_seen, 16'h1000);
    step();

    // Back-to-back with start held high.
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    step();
    a = 16'h00FF; b = 16'h0001;
    t1 = -1; t2 = -1; cyc = 0;
    while (cyc < 30 && t2 < 0) begin
      @(negedge clk);
      if (done) begin
        if (t1 < 0) begin
          t1 = cyc;
          chk("b2b_first", result, 16'h0002);
          @(posedge clk);
          #1;
          start = 1'b0;
        end else begin
          t2 = cyc;
          chk("b2b_second", result, 16'h0100);
        end
      end
      cyc++;
    end
    chk("b2b_spacing", t2 - t1, N + 1);
    step();

    // Reset mid-RUN clears everything and suppresses done.
    a = 16'h5A5A; b = 16'h3C3C; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset_p = 1'b1;
    step();
    reset_p = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    chk("midrst_adder_if", {add_a, add_b, add_cin}, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("midrst_no_done", cnt, 0);
    step();
    do_op("post_rst", 16'h1111, 16'h1111, 1'b0, 16'h2222, 1'b0, 1'b0, cins);

    // Randomized traffic, including starts during RUN and occasional resets.
    for (int i = 0; i < 600; i++) begin
      start   = 1'($urandom_range(0, 1));
      a       = W'($urandom);
      b       = W'($urandom);
      cin     = 1'($urandom_range(0, 1));
      reset_p = ($urandom_range(0, 40) == 0);
      step();
    end
    reset_p = 1'b0;
    start   = 1'b0;
    repeat (N + 3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
